alu_secuencial: RTL and testbench

Registered, parametrised ALU that extends the MIPS-funct combinational ALU with a start/done handshake, status flags and multi-cycle signed multiply and divide. It sits between the operand/opcode registers loaded by the UART interface and the transmit path. It executes one operation at a time. Results and flags are held stable until the next completed operation.

---
 rtl/alu_secuencial_if.sv | 25 ++
 rtl/alu_secuencial.sv | 206 ++++++++++++++++++++
 tb/tb_alu_secuencial.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_secuencial_if.sv
// Handshake and operand/result bundle between the UART-side registers and the sequential ALU.
// The master drives the request and operands; the slave (the ALU) returns status and results.
interface alu_secuencial_if #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
);
    logic              i_start;
    logic [N_BITS-1:0] i_a;
    logic [N_BITS-1:0] i_b;
    logic [N_OP-1:0]   i_op;
    logic              o_busy;
    logic              o_done;
    logic [N_BITS-1:0] o_result;
    logic [3:0]        o_flags;

    modport master (
        output i_start, i_a, i_b, i_op,
        input  o_busy, o_done, o_result, o_flags
    );

    modport slave (
        input  i_start, i_a, i_b, i_op,
        output o_busy, o_done, o_result, o_flags
    );
endinterface

// File: rtl/alu_secuencial.sv
// Registered MIPS-funct ALU with start/done handshake, {Z,N,C,V} flags and
// multi-cycle signed shift-add multiply and restoring divide on operand magnitudes.
module alu_secuencial #(
    parameter int N_BITS   = 8,
    parameter int N_OP     = 6,
    parameter int CNT_BITS = $clog2(N_BITS) + 1
) (
    input logic          i_clk,
    input logic          i_reset,
    alu_secuencial_if.slave bus
);

    localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
    localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
    localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
    localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
    localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
    localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);
    localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);
    localparam logic [N_OP-1:0] OP_SLL = N_OP'(6'b000000);
    localparam logic [N_OP-1:0] OP_MUL = N_OP'(6'b011000);
    localparam logic [N_OP-1:0] OP_DIV = N_OP'(6'b011010);

    localparam logic [N_BITS-1:0] MOST_NEG = {1'b1, {(N_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t                state_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic [N_BITS-1:0]     result_q;
    logic [3:0]            flags_q;
    logic                  isDiv_q;
    logic                  negRes_q;
    logic                  divZero_q;
    logic                  divOvf_q;
    logic [2*N_BITS-1:0]   acc_q;
    logic [2*N_BITS-1:0]   mcand_q;
    logic [N_BITS-1:0]     work_q;

    logic [N_BITS:0]       sumExt;
    logic [N_BITS-1:0]     diff;
    logic                  bigShift;
    logic [N_BITS-1:0]     aluRes;
    logic                  aluC;
    logic                  aluV;
    logic                  opIsMul;
    logic                  opIsDiv;
    logic [N_BITS-1:0]     absA;
    logic [N_BITS-1:0]     absB;

    logic [2*N_BITS-1:0]   accStep;
    logic [2*N_BITS-1:0]   mcandStep;
    logic [N_BITS-1:0]     workStep;
    logic [N_BITS:0]       remShift;
    logic                  qBit;
    logic [2*N_BITS-1:0]   prodFull;
    logic [N_BITS-1:0]     quoSigned;
    logic [N_BITS-1:0]     finalRes;
    logic                  finalV;

    assign opIsMul = (bus.i_op == OP_MUL);
    assign opIsDiv = (bus.i_op == OP_DIV);
    assign absA    = bus.i_a[N_BITS-1] ? (~bus.i_a + 1'b1) : bus.i_a;
    assign absB    = bus.i_b[N_BITS-1] ? (~bus.i_b + 1'b1) : bus.i_b;

    // Single-cycle datapath works straight off the live operands; it only matters on an accepted start.
    always_comb begin
        sumExt   = {1'b0, bus.i_a} + {1'b0, bus.i_b};
        diff     = bus.i_a - bus.i_b;
        bigShift = (bus.i_b >= N_BITS'(N_BITS));
        aluRes   = '0;
        aluC     = 1'b0;
        aluV     = 1'b0;
        case (bus.i_op)
            OP_ADD: begin
                aluRes = sumExt[N_BITS-1:0];
                aluC   = sumExt[N_BITS];
                aluV   = (bus.i_a[N_BITS-1] == bus.i_b[N_BITS-1]) &&
                         (sumExt[N_BITS-1] != bus.i_a[N_BITS-1]);
            end
            OP_SUB: begin
                aluRes = diff;
                aluC   = (bus.i_a < bus.i_b);
                aluV   = (bus.i_a[N_BITS-1] != bus.i_b[N_BITS-1]) &&
                         (diff[N_BITS-1] != bus.i_a[N_BITS-1]);
            end
            OP_AND: aluRes = bus.i_a & bus.i_b;
            OP_OR:  aluRes = bus.i_a | bus.i_b;
            OP_XOR: aluRes = bus.i_a ^ bus.i_b;
            OP_NOR: aluRes = ~(bus.i_a | bus.i_b);
            OP_SLL: aluRes = bigShift ? '0 : (bus.i_a << bus.i_b);
            OP_SRL: aluRes = bigShift ? '0 : (bus.i_a >> bus.i_b);
            OP_SRA: aluRes = bigShift ? {N_BITS{bus.i_a[N_BITS-1]}}
                                      : N_BITS'($signed(bus.i_a) >>> bus.i_b);
            default: aluRes = '0;
        endcase
    end

    // One shift-add or restore-subtract step; for divide acc holds the partial remainder,
    // mcand the divisor and work the dividend bits shifting into quotient bits.
    always_comb begin
        accStep   = acc_q;
        mcandStep = mcand_q << 1;
        workStep  = work_q >> 1;
        remShift  = '0;
        qBit      = 1'b0;
        if (isDiv_q) begin
            remShift = {acc_q[N_BITS-1:0], work_q[N_BITS-1]};
            if (remShift >= {1'b0, mcand_q[N_BITS-1:0]}) begin
                remShift = remShift - {1'b0, mcand_q[N_BITS-1:0]};
                qBit     = 1'b1;
            end
            accStep   = {{N_BITS{1'b0}}, remShift[N_BITS-1:0]};
            mcandStep = mcand_q;
            workStep  = {work_q[N_BITS-2:0], qBit};
        end else if (work_q[0]) begin
            accStep = acc_q + mcand_q;
        end
    end

    // FINISH performs the last iteration together with sign correction.
    always_comb begin
        prodFull  = negRes_q ? (~accStep + 1'b1) : accStep;
        quoSigned = negRes_q ? (~workStep + 1'b1) : workStep;
        if (isDiv_q) begin
            finalRes = divZero_q ? '0 : quoSigned;
            finalV   = divZero_q | divOvf_q;
        end else begin
            finalRes = prodFull[N_BITS-1:0];
            finalV   = !((&prodFull[2*N_BITS-1:N_BITS-1]) || (~|prodFull[2*N_BITS-1:N_BITS-1]));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            divZero_q <= 1'b0;
            divOvf_q  <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            work_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        if (opIsMul || opIsDiv) begin
                            isDiv_q   <= opIsDiv;
                            negRes_q  <= bus.i_a[N_BITS-1] ^ bus.i_b[N_BITS-1];
                            divZero_q <= (bus.i_b == '0);
                            divOvf_q  <= (bus.i_a == MOST_NEG) && (bus.i_b == '1);
                            acc_q     <= '0;
                            mcand_q   <= {{N_BITS{1'b0}}, (opIsDiv ? absB : absA)};
                            work_q    <= opIsDiv ? absA : absB;
                            cnt_q     <= CNT_BITS'(N_BITS);
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end else begin
                            result_q <= aluRes;
                            flags_q  <= {(aluRes == '0), aluRes[N_BITS-1], aluC, aluV};
                            done_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_q   <= accStep;
                    mcand_q <= mcandStep;
                    work_q  <= workStep;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_BITS'(2)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    cnt_q    <= cnt_q - 1'b1;
                    result_q <= finalRes;
                    flags_q  <= {(finalRes == '0), finalRes[N_BITS-1], 1'b0, finalV};
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_result = result_q;
    assign bus.o_flags  = flags_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Scoreboard bench for alu_secuencial: stimulus pushes hand-computed results and done cycles,
// an independent monitor pops and compares on every o_done pulse.
module tb_alu_secuencial;

    localparam int NB = 8;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SLL = 6'b000000;
    localparam logic [5:0] MUL = 6'b011000;
    localparam logic [5:0] DIV = 6'b011010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
        int         doneCycle;
        int         id;
    } exp_t;

    logic clk;
    logic reset;
    int   cycle;
    int   freeEdge;
    int   opId;
    int   checkCount;
    int   passCount;
    int   busyCount;
    exp_t expQ[$];

    alu_secuencial_if #(.N_BITS(NB), .N_OP(6)) bus();

    alu_secuencial #(.N_BITS(NB), .N_OP(6)) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Presents one operation with i_start high and returns at the negedge after it is accepted.
    task automatic applyStimulus(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] expRes, input logic [3:0] expFlags, input bit multi);
        int   lat;
        int   acceptEdge;
        exp_t e;
        lat        = multi ? NB : 0;
        acceptEdge = (cycle + 1 > freeEdge) ? cycle + 1 : freeEdge;
        opId++;
        e.res       = expRes;
        e.flags     = expFlags;
        e.doneCycle = acceptEdge + lat;
        e.id        = opId;
        expQ.push_back(e);
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_start = 1'b1;
        while (cycle < acceptEdge) @(negedge clk);
        freeEdge = acceptEdge + lat + 1;
    endtask

    task automatic drain();
        bus.i_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("pendingDone", expQ.size(), 0);
        expQ.delete();
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("op%0d result", e.id), bus.o_result, e.res);
                    checkOutput($sformatf("op%0d flags", e.id), bus.o_flags, e.flags);
                    checkOutput($sformatf("op%0d doneCycle", e.id), cycle, e.doneCycle);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checkCount  = 0;
        passCount   = 0;
        opId        = 0;
        freeEdge    = 0;
        reset       = 1'b1;
        bus.i_start = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_op    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("resetBusy", bus.o_busy, 0);
        checkOutput("resetDone", bus.o_done, 0);
        checkOutput("resetResult", bus.o_result, 0);
        checkOutput("resetFlags", bus.o_flags, 0);

        $display("[TB] single-cycle operations");
        applyStimulus(ADD, 8'h7F, 8'h01, 8'h80, 4'b0101, 0); drain();
        applyStimulus(SUB, 8'h00, 8'h01, 8'hFF, 4'b0110, 0); drain();
        applyStimulus(SRA, 8'h80, 8'd9,  8'hFF, 4'b0100, 0); drain();
        applyStimulus(SRL, 8'h80, 8'd3,  8'h10, 4'b0000, 0); drain();
        applyStimulus(SLL, 8'h01, 8'd8,  8'h00, 4'b1000, 0); drain();
        applyStimulus(BAD, 8'h12, 8'h34, 8'h00, 4'b1000, 0); drain();
        applyStimulus(AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0);
        applyStimulus(OR,  8'h0F, 8'hF0, 8'hFF, 4'b0100, 0);
        applyStimulus(XOR, 8'hFF, 8'h0F, 8'hF0, 4'b0100, 0);
        applyStimulus(NOR, 8'h00, 8'h00, 8'hFF, 4'b0100, 0);
        applyStimulus(SRA, 8'hB0, 8'd2,  8'hEC, 4'b0100, 0);
        drain();

        $display("[TB] multiply with busy count and ignored mid-busy start");
        applyStimulus(MUL, 8'hFD, 8'h05, 8'hF1, 4'b0100, 1);
        bus.i_start = 1'b0;
        busyCount = 0;
        for (int i = 0; i < NB + 1; i++) begin
            if (bus.o_busy === 1'b1) busyCount++;
            if (i == 3) begin
                bus.i_op    = ADD;
                bus.i_a     = 8'h11;
                bus.i_b     = 8'h22;
                bus.i_start = 1'b1;
            end
            if (i == 4) bus.i_start = 1'b0;
            @(negedge clk);
        end
        checkOutput("mulBusyCycles", busyCount, NB);
        drain();
        applyStimulus(MUL, 8'h10, 8'h10, 8'h00, 4'b1001, 1); drain();

        $display("[TB] divide");
        applyStimulus(DIV, 8'hF9, 8'h02, 8'hFD, 4'b0100, 1); drain();
        applyStimulus(DIV, 8'h05, 8'h00, 8'h00, 4'b1001, 1); drain();
        applyStimulus(DIV, 8'h80, 8'hFF, 8'h80, 4'b0101, 1); drain();

        $display("[TB] reset during multiply");
        applyStimulus(MUL, 8'h03, 8'h05, 8'h0F, 4'b0000, 1);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        freeEdge = cycle + 1;
        checkOutput("abortBusy", bus.o_busy, 0);
        checkOutput("abortDone", bus.o_done, 0);
        checkOutput("abortResult", bus.o_result, 0);
        checkOutput("abortFlags", bus.o_flags, 0);
        repeat (NB + 2) @(negedge clk);
        applyStimulus(ADD, 8'h02, 8'h03, 8'h05, 4'b0000, 0); drain();

        $display("[TB] back-to-back alternating ADD/MUL");
        applyStimulus(ADD, 8'h01, 8'h01, 8'h02, 4'b0000, 0);
        applyStimulus(MUL, 8'h03, 8'h04, 8'h0C, 4'b0000, 1);
        applyStimulus(ADD, 8'h7F, 8'h7F, 8'hFE, 4'b0101, 0);
        applyStimulus(MUL, 8'hFF, 8'hFF, 8'h01, 4'b0000, 1);
        applyStimulus(ADD, 8'hFF, 8'h01, 8'h00, 4'b1010, 0);
        applyStimulus(DIV, 8'h64, 8'hF9, 8'hF2, 4'b0100, 1);
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
